// File: rtl/hs_pkg.sv
// Shared definitions for the picoMIPS switch-handshake driver: FSM state
// encoding, default operand width and the counter-width helper.
package hs_pkg;

    // Default operand width; mirrors N from the picoMIPS global_parameters.sv.
    localparam int N = 8;

    // Driver states. IDLE is the only state that accepts a new word.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } hs_state_e;

    // Width needed to hold the largest cycle count any counter is loaded with.
    function automatic int cnt_width(input int setupCyc, input int holdCyc,
                                     input int presentCyc, input int timeoutCyc);
        int m;
        m = setupCyc;
        if (holdCyc > m) m = holdCyc;
        if (presentCyc > m) m = presentCyc;
        if (timeoutCyc > m) m = timeoutCyc;
        return $clog2(m + 1);
    endfunction

    // Counter width for the default parameter set.
    localparam int CNT_W = cnt_width(2, 2, 16, 0);

endpackage

// File: rtl/hs_downcounter.sv
// Loadable down-counter that stops at zero and flags when it is there.
// Used for both the phase timer and the acknowledge timeout timer.
module hs_downcounter
    import hs_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/handshake_tx.sv
// Host-side driver for the picoMIPS WLD0/WLD1 switch handshake. Takes words
// from a valid/ready stream, puts each on sw_data, flips handshake_switch to
// the level the next WLD waits for, and holds both until the CPU consumed it.
module handshake_tx
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH  = N,
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 2,
    parameter int USE_ACK     = 1,
    parameter int PRESENT_CYC = 16,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  cpu_ack,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] sw_data,
    output logic                  handshake_switch,
    output logic                  busy,
    output logic                  err_spurious,
    output logic                  err_timeout,
    output logic [7:0]            words_sent
);

    localparam int CW = cnt_width(SETUP_CYC, HOLD_CYC, PRESENT_CYC, TIMEOUT_CYC);

    localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] PRESENT_LOAD = CW'(PRESENT_CYC - 1);
    localparam logic [CW-1:0] TMO_LOAD     = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam bit            ACK_MODE     = (USE_ACK != 0);
    localparam bit            TMO_EN       = (TIMEOUT_CYC > 0);

    hs_state_e             state_q, state_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] sw_data_q, sw_data_d;
    logic                  switch_q, switch_d;
    logic                  busy_q;
    logic                  err_spur_q, err_spur_d;
    logic                  err_tmo_q, err_tmo_d;
    logic [7:0]            words_q, words_d;
    logic                  tmo_armed_q, tmo_armed_d;

    logic                  ph_load, ph_dec, ph_zero;
    logic [CW-1:0]         ph_load_val;
    logic                  tmo_load, tmo_dec, tmo_zero;
    logic                  spur_set, tmo_set;

    // Shared timer for SETUP, HOLD and fixed-length PRESENT.
    hs_downcounter #(.WIDTH(CW)) u_phase_cnt (
        .clk        (clk),
        .nReset     (nReset),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .dec_i      (ph_dec),
        .zero_o     (ph_zero)
    );

    // Acknowledge timeout timer, only ever loaded when the timeout is enabled.
    hs_downcounter #(.WIDTH(CW)) u_tmo_cnt (
        .clk        (clk),
        .nReset     (nReset),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .dec_i      (tmo_dec),
        .zero_o     (tmo_zero)
    );

    // Next-state logic: sequence one word through SETUP/PRESENT/HOLD and track errors.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sw_data_d   = sw_data_q;
        switch_d    = switch_q;
        words_d     = words_q;
        tmo_armed_d = tmo_armed_q;
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_dec      = 1'b0;
        tmo_load    = 1'b0;
        tmo_dec     = 1'b0;
        spur_set    = 1'b0;
        tmo_set     = 1'b0;

        case (state_q)
            IDLE: begin
                spur_set = ACK_MODE && cpu_ack;
                if (in_valid) begin
                    sw_data_d   = in_data;
                    ph_load     = 1'b1;
                    ph_load_val = SETUP_LOAD;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                spur_set = ACK_MODE && cpu_ack;
                if (ph_zero) begin
                    switch_d = phase_q;
                    state_d  = PRESENT;
                    if (!ACK_MODE) begin
                        ph_load     = 1'b1;
                        ph_load_val = PRESENT_LOAD;
                    end
                    if (ACK_MODE && TMO_EN) begin
                        tmo_load    = 1'b1;
                        tmo_armed_d = 1'b1;
                    end
                end else begin
                    ph_dec = 1'b1;
                end
            end
            PRESENT: begin
                if (ACK_MODE) begin
                    if (cpu_ack) begin
                        ph_load     = 1'b1;
                        ph_load_val = HOLD_LOAD;
                        tmo_armed_d = 1'b0;
                        state_d     = HOLD;
                    end else if (TMO_EN) begin
                        if (tmo_zero) begin
                            tmo_set     = tmo_armed_q;
                            tmo_armed_d = 1'b0;
                        end else begin
                            tmo_dec = 1'b1;
                        end
                    end
                end else begin
                    if (ph_zero) begin
                        ph_load     = 1'b1;
                        ph_load_val = HOLD_LOAD;
                        state_d     = HOLD;
                    end else begin
                        ph_dec = 1'b1;
                    end
                end
            end
            HOLD: begin
                spur_set = ACK_MODE && cpu_ack;
                if (ph_zero) begin
                    phase_d = ~phase_q;
                    words_d = words_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_spur_d = spur_set ? 1'b1 : (clr_err ? 1'b0 : err_spur_q);
        err_tmo_d  = tmo_set  ? 1'b1 : (clr_err ? 1'b0 : err_tmo_q);
    end

    // State and output registers; the switch idles high so the first WLD0 stalls.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            sw_data_q   <= '0;
            switch_q    <= 1'b1;
            busy_q      <= 1'b0;
            err_spur_q  <= 1'b0;
            err_tmo_q   <= 1'b0;
            words_q     <= 8'd0;
            tmo_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sw_data_q   <= sw_data_d;
            switch_q    <= switch_d;
            busy_q      <= (state_d != IDLE);
            err_spur_q  <= err_spur_d;
            err_tmo_q   <= err_tmo_d;
            words_q     <= words_d;
            tmo_armed_q <= tmo_armed_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign sw_data          = sw_data_q;
    assign handshake_switch = switch_q;
    assign busy             = busy_q;
    assign err_spurious     = err_spur_q;
    assign err_timeout      = err_tmo_q;
    assign words_sent       = words_q;

endmodule

// File: doc/handshake_tx.md
Name: handshake_tx

Overview:
- Host-side driver for the picoMIPS switch handshake consumed by the WLD0/WLD1 instructions.
- Accepts operand words over a valid/ready stream and presents each one on the CPU's switch-data inputs.
- Drives handshake_switch to the level the CPU's next WLD instruction is waiting for, then holds it until the CPU has consumed the word.
- Sits between a test or host source and the picoMIPS top level; replaces a human operator working the switches.

Parameters:
- DATA_WIDTH, 8 (`N` from global_parameters.sv): operand width.
- SETUP_CYC, 2: cycles sw_data is stable before handshake_switch changes. Minimum 1.
- HOLD_CYC, 2: cycles data and switch stay stable after the word is consumed. Minimum 1.
- USE_ACK, 1: 1 = wait for cpu_ack; 0 = fixed-time presentation.
- PRESENT_CYC, 16: presentation length when USE_ACK=0.
- TIMEOUT_CYC, 0: ack timeout in PRESENT. 0 = disabled.

Ports:
- clk, input, 1: system clock.
- nReset, input, 1: asynchronous active-low reset.
- in_data, input, DATA_WIDTH: word to send.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- cpu_ack, input, 1: one-cycle pulse when the CPU executes WLD0/WLD1 with a matching switch level (decoder w and pc_inc on a WLD opcode).
- clr_err, input, 1: synchronous clear of the sticky error flags.
- sw_data, output, DATA_WIDTH: data presented on the CPU switch inputs.
- handshake_switch, output, 1: handshake level to the decoder.
- busy, output, 1: high in any state other than IDLE.
- err_spurious, output, 1: sticky; cpu_ack arrived outside PRESENT.
- err_timeout, output, 1: sticky; no ack within TIMEOUT_CYC.
- words_sent, output, 8: count of completed words, wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, nReset=0):
  - state=IDLE, phase=0, sw_data=0, handshake_switch=1, in_ready=1 (after release), busy=0, both error flags=0, words_sent=0.
  - handshake_switch=1 at reset means the CPU's first WLD0 stalls until a word is actually presented.
- Registered outputs: all outputs are registered except in_ready, which is combinational: in_ready = (state==IDLE).
- State IDLE:
  - On a handshake (in_valid & in_ready) at edge t: sw_data <= in_data, counter <= SETUP_CYC-1, state <= SETUP.
  - handshake_switch keeps its previous level.
- State SETUP:
  - Count down; when the counter reaches 0: handshake_switch <= phase, state <= PRESENT.
  - Result: the switch changes exactly SETUP_CYC cycles after sw_data was loaded.
- State PRESENT, USE_ACK=1:
  - Wait for cpu_ack sampled high; then counter <= HOLD_CYC-1, state <= HOLD.
  - If TIMEOUT_CYC>0 and TIMEOUT_CYC cycles pass in PRESENT without an ack: err_timeout <= 1, and the block stays in PRESENT. There is no abort.
- State PRESENT, USE_ACK=0:
  - Leave for HOLD after exactly PRESENT_CYC cycles.
  - cpu_ack is ignored and never flags an error.
- State HOLD:
  - Count down; when the counter reaches 0: phase <= ~phase, words_sent <= words_sent+1, state <= IDLE.
  - sw_data and handshake_switch are unchanged on exit; the line stays at its last level.
- Phase sequence: the first word presents switch 0 (WLD0), the second presents 1 (WLD1), and so on, alternating. The switch toggles exactly once per word.
- Spurious ack: cpu_ack high in IDLE, SETUP or HOLD with USE_ACK=1 sets err_spurious and causes no state change.
- Error clearing: if clr_err and a set condition occur in the same cycle, set wins.
- in_valid while not in IDLE: the word is not accepted (in_ready=0); the source must hold it.
- Minimum latency, acceptance to ready again: SETUP_CYC + 1 (ack earliest) + HOLD_CYC cycles.
- Reset mid-operation: immediate return to reset values. The word in flight is lost and phase returns to 0. The CPU program must also be reset so its next WLD is a WLD0.

Decomposition:
- Package hs_pkg: state enum typedef (IDLE, SETUP, PRESENT, HOLD) and the counter width localparam $clog2(max(SETUP_CYC, HOLD_CYC, PRESENT_CYC, TIMEOUT_CYC)+1).
- DATA_WIDTH default comes from global_parameters.sv.
- One sub-module, hs_downcounter: load value, load enable, decrement, zero flag. Instantiated twice:
  - phase counter, shared by SETUP, HOLD and fixed-PRESENT;
  - timeout counter.

Test Plan:
1. Reset, then send 8'hA5 with USE_ACK=1 and ack 3 cycles into PRESENT -> sw_data=A5 one cycle after acceptance; switch 1->0 exactly 2 cycles later; ready again 2 cycles after the ack; words_sent=1.
2. Send 8'h11, 8'h22, 8'h33 back-to-back -> switch levels 0, 1, 0; each data change precedes its switch change by 2 cycles; words_sent=3.
3. cpu_ack pulsed in IDLE and again during SETUP -> err_spurious=1 and no state advance; clr_err clears it; the later valid ack completes normally.
4. TIMEOUT_CYC=10, no ack -> err_timeout set after 10 PRESENT cycles while the switch stays asserted; a late ack still completes the word.
5. USE_ACK=0, PRESENT_CYC=16 -> switch held exactly 16 cycles before HOLD; cpu_ack toggling has no effect and sets no error.
6. Assert nReset during PRESENT of the second word -> asynchronously handshake_switch=1, sw_data=0, busy=0, phase=0; the next word presents switch 0.
